// File: rtl/multicycle_ctrl_if.sv
// Unified memory port handshake between the multi-cycle controller and memory.
// The controller holds mem_req until the memory answers with mem_ready.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_fetch;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output mem_fetch, input mem_ready);
  modport slave  (input mem_req, input mem_we, input mem_fetch, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control unit: decodes IR and steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, driving every datapath enable and a sticky fault.
module multicycle_ctrl #(
  parameter int TIMEOUT     = 16,
  parameter int RFIDX_WIDTH = 5
) (
  input  logic                clk,
  input  logic                rstn,
  multicycle_ctrl_if.master   mem,
  input  logic [31:0]         ir,
  input  logic                zero,
  input  logic                lt,
  input  logic                ltu,
  output logic                ir_we,
  output logic                pc_we,
  output logic [1:0]          pc_src,
  output logic                rf_we,
  output logic [1:0]          rf_wd_sel,
  output logic                alu_a_sel,
  output logic                alu_b_sel,
  output logic [3:0]          alu_ctrl,
  output logic [5:0]          ext_ctrl,
  output logic [1:0]          lsize,
  output logic                l_unsigned,
  output logic [2:0]          state,
  output logic                fault,
  output logic                instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_OR = 4'd8, ALU_AND = 4'd9;

  localparam logic [5:0] EXT_SHAMT = 6'b100000, EXT_I = 6'b010000, EXT_S = 6'b001000;
  localparam logic [5:0] EXT_B = 6'b000100, EXT_U = 6'b000010, EXT_J = 6'b000001;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t cur, nxt;
  logic [7:0] wait_cnt;
  logic       req, we, fetch;
  logic       legal, taken, sel_active, time_up;
  logic [3:0] alu_fn;

  logic [6:0]             opcode;
  logic [2:0]             funct3;
  logic [6:0]             funct7;
  logic [RFIDX_WIDTH-1:0] rd;
  logic                   rd_nz;
  logic                   unused_ir;

  assign opcode    = ir[6:0];
  assign funct3    = ir[14:12];
  assign funct7    = ir[31:25];
  assign rd        = ir[7 +: RFIDX_WIDTH];
  assign rd_nz     = |rd;
  assign unused_ir = ^ir[24:15];

  logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_opimm, is_op;
  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_opimm  = (opcode == OPC_OPIMM);
  assign is_op     = (opcode == OPC_OP);

  // Reject unknown opcodes and funct3/funct7 combinations RV32I leaves undefined.
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: legal = 1'b1;
      OPC_JALR:   legal = (funct3 == 3'd0);
      OPC_BRANCH: legal = (funct3 != 3'd2) && (funct3 != 3'd3);
      OPC_LOAD:   legal = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
      OPC_STORE:  legal = (funct3 <= 3'd2);
      OPC_OPIMM: begin
        if (funct3 == 3'd1)      legal = (funct7 == 7'h00);
        else if (funct3 == 3'd5) legal = (funct7 == 7'h00) || (funct7 == 7'h20);
        else                     legal = 1'b1;
      end
      OPC_OP: legal = (funct7 == 7'h00) ||
                      ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_fn = ALU_ADD;
    case (funct3)
      3'd0: alu_fn = (is_op && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'd1: alu_fn = ALU_SLL;
      3'd2: alu_fn = ALU_SLT;
      3'd3: alu_fn = ALU_SLTU;
      3'd4: alu_fn = ALU_XOR;
      3'd5: alu_fn = funct7[5] ? ALU_SRA : ALU_SRL;
      3'd6: alu_fn = ALU_OR;
      default: alu_fn = ALU_AND;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'd0: taken = zero;
      3'd1: taken = ~zero;
      3'd4: taken = lt;
      3'd5: taken = ~lt;
      3'd6: taken = ltu;
      3'd7: taken = ~ltu;
      default: taken = 1'b0;
    endcase
  end

  // Datapath selects are only meaningful once IR holds the decoded instruction.
  assign sel_active = (cur == S_EXEC) || (cur == S_MEM) || (cur == S_WB);

  always_comb begin
    alu_ctrl   = ALU_ADD;
    alu_a_sel  = 1'b0;
    alu_b_sel  = 1'b0;
    rf_wd_sel  = 2'd0;
    ext_ctrl   = 6'd0;
    lsize      = 2'd0;
    l_unsigned = 1'b0;
    if (sel_active) begin
      if (is_op) begin
        alu_ctrl = alu_fn;
      end else if (is_opimm) begin
        alu_ctrl  = alu_fn;
        alu_b_sel = 1'b1;
        ext_ctrl  = ((funct3 == 3'd1) || (funct3 == 3'd5)) ? EXT_SHAMT : EXT_I;
      end else if (is_branch) begin
        alu_ctrl = ALU_SUB;
        ext_ctrl = EXT_B;
      end else if (is_load || is_store) begin
        alu_b_sel  = 1'b1;
        ext_ctrl   = is_load ? EXT_I : EXT_S;
        lsize      = funct3[1:0];
        l_unsigned = is_load & funct3[2];
        rf_wd_sel  = is_load ? 2'd1 : 2'd0;
      end else if (is_jal) begin
        alu_a_sel = 1'b1;
        alu_b_sel = 1'b1;
        ext_ctrl  = EXT_J;
        rf_wd_sel = 2'd2;
      end else if (is_jalr) begin
        alu_b_sel = 1'b1;
        ext_ctrl  = EXT_I;
        rf_wd_sel = 2'd2;
      end else if (is_lui) begin
        alu_b_sel = 1'b1;
        ext_ctrl  = EXT_U;
        rf_wd_sel = 2'd3;
      end else if (is_auipc) begin
        alu_a_sel = 1'b1;
        alu_b_sel = 1'b1;
        ext_ctrl  = EXT_U;
      end
    end
  end

  // Last tolerated wait cycle: a stall here means the bus has hung.
  assign time_up = (wait_cnt == WAIT_LAST) && !mem.mem_ready;

  always_comb begin
    nxt     = cur;
    req     = 1'b0;
    we      = 1'b0;
    fetch   = 1'b0;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    pc_src  = 2'd0;
    rf_we   = 1'b0;
    instret = 1'b0;
    case (cur)
      S_FETCH: begin
        req   = 1'b1;
        fetch = 1'b1;
        if (mem.mem_ready) begin
          ir_we = 1'b1;
          nxt   = S_DECODE;
        end else if (time_up) begin
          nxt = S_FAULT;
        end
      end
      S_DECODE: nxt = legal ? S_EXEC : S_FAULT;
      S_EXEC: begin
        if (is_branch) begin
          pc_we   = 1'b1;
          pc_src  = taken ? 2'd1 : 2'd0;
          instret = 1'b1;
          nxt     = S_FETCH;
        end else if (is_jal || is_jalr) begin
          rf_we   = rd_nz;
          pc_we   = 1'b1;
          pc_src  = is_jalr ? 2'd2 : 2'd1;
          instret = 1'b1;
          nxt     = S_FETCH;
        end else if (is_load || is_store) begin
          nxt = S_MEM;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        req = 1'b1;
        we  = is_store;
        if (mem.mem_ready) begin
          if (is_store) begin
            pc_we   = 1'b1;
            instret = 1'b1;
            nxt     = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end else if (time_up) begin
          nxt = S_FAULT;
        end
      end
      S_WB: begin
        rf_we   = rd_nz;
        pc_we   = 1'b1;
        instret = 1'b1;
        nxt     = S_FETCH;
      end
      S_FAULT: nxt = S_FAULT;
      default: nxt = S_FAULT;
    endcase
    if (!rstn) begin
      req     = 1'b0;
      we      = 1'b0;
      fetch   = 1'b0;
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      pc_src  = 2'd0;
      rf_we   = 1'b0;
      instret = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cur <= S_FETCH;
    else       cur <= nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                        wait_cnt <= 8'd0;
    else if (req && !mem.mem_ready)   wait_cnt <= wait_cnt + 8'd1;
    else                              wait_cnt <= 8'd0;
  end

  assign mem.mem_req   = req;
  assign mem.mem_we    = we;
  assign mem.mem_fetch = fetch;
  assign state         = cur;
  assign fault         = (cur == S_FAULT);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven bench for multicycle_ctrl: per-cycle vectors push expected
// outputs into a scoreboard that a sampler pops mid-cycle and compares.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       req, we, fetch, irwe, pcwe;
    logic [1:0] pcsrc;
    logic       rfwe, ret, flt;
  } ctl_t;

  typedef struct packed {
    logic [3:0] alu;
    logic       asel, bsel;
    logic [1:0] wdsel, lsz;
    logic       lun;
    logic [5:0] ext;
  } sel_t;

  typedef struct {
    string       name;
    logic        rn;
    logic [31:0] ir;
    logic        rdy, z, l, lu;
    ctl_t        ctl;
    logic        chk;
    sel_t        sel;
  } vec_t;

  typedef struct {
    string name;
    ctl_t  ctl;
    logic  chk;
    sel_t  sel;
  } exp_t;

  logic clk, rstn;
  logic [31:0] ir;
  logic zero, lt, ltu;
  logic ir_we, pc_we, rf_we, alu_a_sel, alu_b_sel, l_unsigned, fault, instret;
  logic [1:0] pc_src, rf_wd_sel, lsize;
  logic [3:0] alu_ctrl;
  logic [5:0] ext_ctrl;
  logic [2:0] state;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.TIMEOUT(16), .RFIDX_WIDTH(5)) dut (
    .clk(clk), .rstn(rstn), .mem(bus), .ir(ir), .zero(zero), .lt(lt), .ltu(ltu),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .rf_we(rf_we), .rf_wd_sel(rf_wd_sel),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_ctrl(alu_ctrl), .ext_ctrl(ext_ctrl),
    .lsize(lsize), .l_unsigned(l_unsigned), .state(state), .fault(fault), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sbq[$];
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  function automatic ctl_t C(input logic [2:0] st, input logic req, we, fe, irw, pcw,
                             input logic [1:0] ps, input logic rfw, ret, flt);
    return {st, req, we, fe, irw, pcw, ps, rfw, ret, flt};
  endfunction

  function automatic sel_t S(input logic [3:0] alu, input logic a, b, input logic [1:0] wd, ls,
                             input logic un, input logic [5:0] ext);
    return {alu, a, b, wd, ls, un, ext};
  endfunction

  function automatic vec_t V(input string n, input logic rn, input logic [31:0] i,
                             input logic rdy, z, l, lu, input ctl_t c, input logic chk, input sel_t s);
    vec_t v;
    v.name = n; v.rn = rn; v.ir = i; v.rdy = rdy; v.z = z; v.l = l; v.lu = lu;
    v.ctl = c; v.chk = chk; v.sel = s;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(negedge clk);
    rstn = v.rn; ir = v.ir; bus.mem_ready = v.rdy; zero = v.z; lt = v.l; ltu = v.lu;
    e.name = v.name; e.ctl = v.ctl; e.chk = v.chk; e.sel = v.sel;
    sbq.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    ctl_t act_ctl;
    sel_t act_sel;
    act_ctl = {state, bus.mem_req, bus.mem_we, bus.mem_fetch, ir_we, pc_we, pc_src, rf_we, instret, fault};
    act_sel = {alu_ctrl, alu_a_sel, alu_b_sel, rf_wd_sel, lsize, l_unsigned, ext_ctrl};
    n_checks++;
    if (act_ctl !== e.ctl) begin
      n_fails++;
      $display("[TB] FAIL %s ctl: got %h expected %h", e.name, act_ctl, e.ctl);
    end
    if (e.chk) begin
      n_checks++;
      if (act_sel !== e.sel) begin
        n_fails++;
        $display("[TB] FAIL %s sel: got %h expected %h", e.name, act_sel, e.sel);
      end
    end
  endtask

  always @(negedge clk) begin
    #3;
    if (sbq.size() != 0) checkOutput(sbq.pop_front());
  end

  initial begin
    ctl_t c_fetch, c_fwait, c_dec, c_idle, c_fault, c_ex, c_wb, c_wb0;
    sel_t s0, s_addi, s_lw, s_lbu, s_sw, s_br, s_jal, s_jalr, s_lui, s_auipc, s_sub, s_srai;
    logic [31:0] ADDI, LW, LBU, SW, BEQ, BLT, BGEU, BNE, JAL0, JALR1, LUI, AUIPC, SUB, SRAI, ADDX0, BADOP, BADF7;

    ADDI = 32'h00500093; LW = 32'h0040A103; LBU = 32'h0000C303; SW = 32'h0020A423;
    BEQ = 32'h00108463; BLT = 32'h0010C463; BGEU = 32'h0010F463; BNE = 32'h00109463;
    JAL0 = 32'h0100006F; JALR1 = 32'h000100E7; LUI = 32'h123452B7; AUIPC = 32'h00001197;
    SUB = 32'h402081B3; SRAI = 32'h4030D213; ADDX0 = 32'h00208033;
    BADOP = 32'hFFFFFFFF; BADF7 = 32'h402091B3;

    c_fetch = C(0,1,0,1,1,0,2'd0,0,0,0);
    c_fwait = C(0,1,0,1,0,0,2'd0,0,0,0);
    c_dec   = C(1,0,0,0,0,0,2'd0,0,0,0);
    c_idle  = C(0,0,0,0,0,0,2'd0,0,0,0);
    c_fault = C(5,0,0,0,0,0,2'd0,0,0,1);
    c_ex    = C(2,0,0,0,0,0,2'd0,0,0,0);
    c_wb    = C(4,0,0,0,0,1,2'd0,1,1,0);
    c_wb0   = C(4,0,0,0,0,1,2'd0,0,1,0);

    s0      = '0;
    s_addi  = S(4'd0,0,1,2'd0,2'd0,0,6'b010000);
    s_lw    = S(4'd0,0,1,2'd1,2'd2,0,6'b010000);
    s_lbu   = S(4'd0,0,1,2'd1,2'd0,1,6'b010000);
    s_sw    = S(4'd0,0,1,2'd0,2'd2,0,6'b001000);
    s_br    = S(4'd1,0,0,2'd0,2'd0,0,6'b000100);
    s_jal   = S(4'd0,1,1,2'd2,2'd0,0,6'b000001);
    s_jalr  = S(4'd0,0,1,2'd2,2'd0,0,6'b010000);
    s_lui   = S(4'd0,0,1,2'd3,2'd0,0,6'b000010);
    s_auipc = S(4'd0,1,1,2'd0,2'd0,0,6'b000010);
    s_sub   = S(4'd1,0,0,2'd0,2'd0,0,6'b000000);
    s_srai  = S(4'd7,0,1,2'd0,2'd0,0,6'b100000);

    tbl.push_back(V("reset",     0, ADDI, 1,0,0,0, c_idle, 1, s0));
    tbl.push_back(V("addi_f",    1, ADDI, 1,0,0,0, c_fetch, 1, s0));
    tbl.push_back(V("addi_d",    1, ADDI, 1,0,0,0, c_dec, 1, s0));
    tbl.push_back(V("addi_e",    1, ADDI, 1,0,0,0, c_ex, 1, s_addi));
    tbl.push_back(V("addi_wb",   1, ADDI, 1,0,0,0, c_wb, 1, s_addi));
    tbl.push_back(V("lw_f",      1, LW, 1,0,0,0, c_fetch, 1, s0));
    tbl.push_back(V("lw_d",      1, LW, 1,0,0,0, c_dec, 1, s0));
    tbl.push_back(V("lw_e",      1, LW, 1,0,0,0, c_ex, 1, s_lw));
    for (int i = 0; i < 3; i++)
      tbl.push_back(V("lw_mwait", 1, LW, 0,0,0,0, C(3,1,0,0,0,0,2'd0,0,0,0), 1, s_lw));
    tbl.push_back(V("lw_m",      1, LW, 1,0,0,0, C(3,1,0,0,0,0,2'd0,0,0,0), 1, s_lw));
    tbl.push_back(V("lw_wb",     1, LW, 1,0,0,0, c_wb, 1, s_lw));
    tbl.push_back(V("lbu_f",     1, LBU, 1,0,0,0, c_fetch, 0, s0));
    tbl.push_back(V("lbu_d",     1, LBU, 1,0,0,0, c_dec, 0, s0));
    tbl.push_back(V("lbu_e",     1, LBU, 1,0,0,0, c_ex, 1, s_lbu));
    tbl.push_back(V("lbu_m",     1, LBU, 1,0,0,0, C(3,1,0,0,0,0,2'd0,0,0,0), 1, s_lbu));
    tbl.push_back(V("lbu_wb",    1, LBU, 1,0,0,0, c_wb, 1, s_lbu));
    tbl.push_back(V("sw_f",      1, SW, 1,0,0,0, c_fetch, 0, s0));
    tbl.push_back(V("sw_d",      1, SW, 1,0,0,0, c_dec, 0, s0));
    tbl.push_back(V("sw_e",      1, SW, 1,0,0,0, c_ex, 1, s_sw));
    tbl.push_back(V("sw_m",      1, SW, 1,0,0,0, C(3,1,1,0,0,1,2'd0,0,1,0), 1, s_sw));
    tbl.push_back(V("beq_t_f",   1, BEQ, 1,1,0,0, c_fetch, 0, s0));
    tbl.push_back(V("beq_t_d",   1, BEQ, 1,1,0,0, c_dec, 0, s0));
    tbl.push_back(V("beq_t_e",   1, BEQ, 1,1,0,0, C(2,0,0,0,0,1,2'd1,0,1,0), 1, s_br));
    tbl.push_back(V("beq_n_f",   1, BEQ, 1,0,0,0, c_fetch, 0, s0));
    tbl.push_back(V("beq_n_d",   1, BEQ, 1,0,0,0, c_dec, 0, s0));
    tbl.push_back(V("beq_n_e",   1, BEQ, 1,0,0,0, C(2,0,0,0,0,1,2'd0,0,1,0), 1, s_br));
    tbl.push_back(V("blt_f",     1, BLT, 1,1,1,0, c_fetch, 0, s0));
    tbl.push_back(V("blt_d",     1, BLT, 1,1,1,0, c_dec, 0, s0));
    tbl.push_back(V("blt_e",     1, BLT, 1,1,1,0, C(2,0,0,0,0,1,2'd1,0,1,0), 1, s_br));
    tbl.push_back(V("bgeu_f",    1, BGEU, 1,0,0,1, c_fetch, 0, s0));
    tbl.push_back(V("bgeu_d",    1, BGEU, 1,0,0,1, c_dec, 0, s0));
    tbl.push_back(V("bgeu_e",    1, BGEU, 1,0,0,1, C(2,0,0,0,0,1,2'd0,0,1,0), 1, s_br));
    tbl.push_back(V("bne_f",     1, BNE, 1,0,0,0, c_fetch, 0, s0));
    tbl.push_back(V("bne_d",     1, BNE, 1,0,0,0, c_dec, 0, s0));
    tbl.push_back(V("bne_e",     1, BNE, 1,0,0,0, C(2,0,0,0,0,1,2'd1,0,1,0), 1, s_br));
    tbl.push_back(V("jal_f",     1, JAL0, 1,0,0,0, c_fetch, 0, s0));
    tbl.push_back(V("jal_d",     1, JAL0, 1,0,0,0, c_dec, 0, s0));
    tbl.push_back(V("jal_e",     1, JAL0, 1,0,0,0, C(2,0,0,0,0,1,2'd1,0,1,0), 1, s_jal));
    tbl.push_back(V("jalr_f",    1, JALR1, 1,0,0,0, c_fetch, 0, s0));
    tbl.push_back(V("jalr_d",    1, JALR1, 1,0,0,0, c_dec, 0, s0));
    tbl.push_back(V("jalr_e",    1, JALR1, 1,0,0,0, C(2,0,0,0,0,1,2'd2,1,1,0), 1, s_jalr));
    tbl.push_back(V("lui_f",     1, LUI, 1,0,0,0, c_fetch, 0, s0));
    tbl.push_back(V("lui_d",     1, LUI, 1,0,0,0, c_dec, 0, s0));
    tbl.push_back(V("lui_e",     1, LUI, 1,0,0,0, c_ex, 1, s_lui));
    tbl.push_back(V("lui_wb",    1, LUI, 1,0,0,0, c_wb, 1, s_lui));
    tbl.push_back(V("auipc_f",   1, AUIPC, 1,0,0,0, c_fetch, 0, s0));
    tbl.push_back(V("auipc_d",   1, AUIPC, 1,0,0,0, c_dec, 0, s0));
    tbl.push_back(V("auipc_e",   1, AUIPC, 1,0,0,0, c_ex, 1, s_auipc));
    tbl.push_back(V("auipc_wb",  1, AUIPC, 1,0,0,0, c_wb, 1, s_auipc));
    tbl.push_back(V("sub_f",     1, SUB, 1,0,0,0, c_fetch, 0, s0));
    tbl.push_back(V("sub_d",     1, SUB, 1,0,0,0, c_dec, 0, s0));
    tbl.push_back(V("sub_e",     1, SUB, 1,0,0,0, c_ex, 1, s_sub));
    tbl.push_back(V("sub_wb",    1, SUB, 1,0,0,0, c_wb, 1, s_sub));
    tbl.push_back(V("srai_f",    1, SRAI, 1,0,0,0, c_fetch, 0, s0));
    tbl.push_back(V("srai_d",    1, SRAI, 1,0,0,0, c_dec, 0, s0));
    tbl.push_back(V("srai_e",    1, SRAI, 1,0,0,0, c_ex, 1, s_srai));
    tbl.push_back(V("srai_wb",   1, SRAI, 1,0,0,0, c_wb, 1, s_srai));
    tbl.push_back(V("addx0_f",   1, ADDX0, 1,0,0,0, c_fetch, 0, s0));
    tbl.push_back(V("addx0_d",   1, ADDX0, 1,0,0,0, c_dec, 0, s0));
    tbl.push_back(V("addx0_e",   1, ADDX0, 1,0,0,0, c_ex, 0, s0));
    tbl.push_back(V("addx0_wb",  1, ADDX0, 1,0,0,0, c_wb0, 1, s0));

    rstn = 1'b1; ir = '0; bus.mem_ready = 1'b0; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
    #1 rstn = 1'b0;
    $display("[TB] running %0d table vectors", tbl.size());
    foreach (tbl[i]) applyStimulus(tbl[i]);

    // Illegal opcode: absorbing fault, then reset recovers to a fetch.
    applyStimulus(V("badop_f", 1, BADOP, 1,0,0,0, c_fetch, 1, s0));
    applyStimulus(V("badop_d", 1, BADOP, 1,0,0,0, c_dec, 1, s0));
    for (int i = 0; i < 22; i++)
      applyStimulus(V("badop_fault", 1, BADOP, 1,1,1,1, c_fault, 1, s0));
    applyStimulus(V("fault_rst", 0, BADOP, 1,0,0,0, c_idle, 1, s0));
    applyStimulus(V("fault_rel", 1, BADF7, 0,0,0,0, c_fwait, 1, s0));
    applyStimulus(V("badf7_f",   1, BADF7, 1,0,0,0, c_fetch, 1, s0));
    applyStimulus(V("badf7_d",   1, BADF7, 1,0,0,0, c_dec, 1, s0));
    applyStimulus(V("badf7_fault", 1, BADF7, 1,0,0,0, c_fault, 1, s0));
    applyStimulus(V("to_rst",    0, ADDI, 0,0,0,0, c_idle, 1, s0));

    // Bus never answers: fault after the sixteenth request cycle.
    for (int i = 0; i < 16; i++)
      applyStimulus(V("to_wait", 1, ADDI, 0,0,0,0, c_fwait, 1, s0));
    for (int i = 0; i < 3; i++)
      applyStimulus(V("to_fault", 1, ADDI, 1,0,0,0, c_fault, 1, s0));
    applyStimulus(V("to2_rst",   0, ADDI, 0,0,0,0, c_idle, 1, s0));

    // Ready on the last tolerated cycle completes normally.
    for (int i = 0; i < 15; i++)
      applyStimulus(V("to2_wait", 1, ADDI, 0,0,0,0, c_fwait, 1, s0));
    applyStimulus(V("to2_f",     1, ADDI, 1,0,0,0, c_fetch, 1, s0));
    applyStimulus(V("to2_d",     1, ADDI, 1,0,0,0, c_dec, 1, s0));
    applyStimulus(V("to2_e",     1, ADDI, 1,0,0,0, c_ex, 1, s_addi));

    // Reset where WB would have been: no register or PC write escapes.
    applyStimulus(V("mid_rst",   0, ADDI, 1,0,0,0, c_idle, 1, s0));
    applyStimulus(V("mid_f",     1, ADDI, 1,0,0,0, c_fetch, 1, s0));
    applyStimulus(V("mid_d",     1, ADDI, 1,0,0,0, c_dec, 1, s0));

    repeat (4) @(negedge clk);
    #4;
    if (sbq.size() != 0) begin
      n_checks++;
      n_fails++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
